// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register word
// offsets, STATUS bit positions, TX state encoding and the divisor clamp.
package mmio_uart_tx_pkg;

    // Register word offsets, taken from adr[3:2]
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    // STATUS bit positions
    localparam int ST_BIT_BUSY  = 0;
    localparam int ST_BIT_FULL  = 1;
    localparam int ST_BIT_EMPTY = 2;
    localparam int ST_BIT_OVF   = 3;
    localparam int ST_CNT_LSB   = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A divisor of zero would stall the baud counter, so it behaves as one.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO for the TX byte queue. A push while full is accepted only
// when a pop happens in the same cycle. DEPTH must be a power of two, 2..8.
module mmio_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory port.
// Decodes a 16-byte window, holds DIVISOR and the sticky overflow flag,
// queues bytes in a small FIFO and serialises them LSB first.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   TX_IDLE  | txd high; pops the FIFO head and latches div when not empty
//   TX_START | start bit (txd=0) for div cycles
//   TX_DATA  | eight data bits, LSB first, div cycles each
//   TX_STOP  | stop bit (txd=1) for div cycles, then back to TX_IDLE
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic        MemWrite,
    input  logic [31:0] writedata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        tx_idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    offset;
    logic          wr_en;
    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [3:0]    count4;
    logic [7:0]    fifo_head;
    logic          ovf_q;
    logic [15:0]   divisor_q;
    logic [15:0]   div_eff;
    logic [15:0]   div_q;
    logic [15:0]   baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    tx_state_e     state_q;
    logic          unused_bits;

    assign offset   = adr[3:2];
    assign hit      = (adr[31:4] == BASE_ADDR[31:4]);
    assign wr_en    = MemWrite && hit;
    assign push_req = wr_en && (offset == OFF_TXDATA);
    assign pop      = (state_q == TX_IDLE) && !fifo_empty;
    assign div_eff  = eff_div(divisor_q);
    assign count4   = 4'(fifo_count);
    assign tx_idle  = fifo_empty && (state_q == TX_IDLE);

    // Byte lanes and address bits that no register uses.
    assign unused_bits = ^{adr[1:0], writedata[31:16]};

    mmio_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_req),
        .push_data (writedata[7:0]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky overflow: set when a push is dropped, cleared by STATUS[3]=1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (wr_en && (offset == OFF_STATUS) && writedata[ST_BIT_OVF]) begin
            ovf_q <= 1'b0;
        end
    end

    // DIVISOR register; the TX path only samples it at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor_q <= CLK_DIV;
        end else if (wr_en && (offset == OFF_DIVISOR)) begin
            divisor_q <= writedata[15:0];
        end
    end

    // Read mux: combinational from adr, zero outside the window.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                OFF_STATUS: begin
                    rdata[ST_BIT_BUSY]         = (state_q != TX_IDLE);
                    rdata[ST_BIT_FULL]         = fifo_full;
                    rdata[ST_BIT_EMPTY]        = fifo_empty;
                    rdata[ST_BIT_OVF]          = ovf_q;
                    rdata[ST_CNT_LSB +: 4]     = count4;
                end
                OFF_DIVISOR: rdata[15:0] = divisor_q;
                OFF_TXDATA:  rdata = '0;
                OFF_RSVD:    rdata = '0;
            endcase
        end
    end

    // TX FSM; txd is registered and each bit lasts baud_q = div-1 .. 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            txd     <= 1'b1;
            shift_q <= '0;
            div_q   <= 16'd1;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_head;
                        div_q   <= div_eff;
                        baud_q  <= div_eff - 16'd1;
                        bit_q   <= '0;
                        txd     <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_q == '0) begin
                        baud_q  <= div_q - 16'd1;
                        txd     <= shift_q[0];
                        state_q <= TX_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            txd     <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            txd     <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (baud_q == '0) begin
                        state_q <= TX_IDLE;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus accesses with register checks, and a
// serial-line monitor that matches each frame on txd against a queue of
// expected {byte, bit period} entries pushed by the stimulus.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] writedata = '0;
    logic        hit;
    logic [31:0] rdata;
    logic        txd;
    logic        tx_idle;

    int     total = 0;
    int     bad = 0;
    frame_t sb_q[$];
    bit     mon_busy = 1'b0;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (16'd868),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adr       (adr),
        .MemWrite  (MemWrite),
        .writedata (writedata),
        .hit       (hit),
        .rdata     (rdata),
        .txd       (txd),
        .tx_idle   (tx_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        adr = a;
        writedata = d;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        adr = a;
        MemWrite = 1'b0;
        #1;
        d = rdata;
    endtask

    task automatic expect_frame(input logic [7:0] d, input int div);
        frame_t f;
        f.data = d;
        f.div  = div;
        sb_q.push_back(f);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && !mon_busy && tx_idle) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: drain timeout, frames pending=%0d tx_idle=%0b required 0/1",
                     name, sb_q.size(), tx_idle);
        end
    endtask

    // Serial monitor: on each falling edge of txd, pop the expected frame and
    // check every cycle of it; a reset during the frame discards it.
    initial begin : monitor
        logic       prev;
        logic [9:0] obs;
        logic [9:0] want;
        bit         glitch;
        bit         aborted;
        frame_t     f;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else begin
                if (prev && !txd) begin
                    mon_busy = 1'b1;
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: start bit on txd, none required");
                    end else begin
                        f = sb_q.pop_front();
                        obs = '0;
                        glitch = 1'b0;
                        aborted = 1'b0;
                        want = {1'b1, f.data, 1'b0};
                        for (int n = 0; n < 10 * f.div; n++) begin
                            if (n > 0) @(negedge clk);
                            if (!rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (n % f.div == 0) obs[n / f.div] = txd;
                            else if (txd !== obs[n / f.div]) glitch = 1'b1;
                        end
                        if (!aborted) begin
                            total++;
                            if (obs !== want || glitch) begin
                                bad++;
                                $display("FAIL frame_%02h: got bits %b%s required %b div=%0d",
                                         f.data, obs, glitch ? " (unstable)" : "", want, f.div);
                            end
                        end
                    end
                    mon_busy = 1'b0;
                end
                prev = txd;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] r;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check("txd_in_reset", {31'b0, txd}, 32'h1);
        check("tx_idle_in_reset", {31'b0, tx_idle}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        bus_read(BASE + 32'h4, r);
        check("status_reset", r, 32'h0000_0004);
        bus_read(BASE + 32'h8, r);
        check("divisor_reset", r, 32'd868);
        check("hit_in_window", {31'b0, hit}, 32'h1);
        bus_read(BASE + 32'h9, r);
        check("divisor_low_adr_bits_ignored", r, 32'd868);
        check("txd_idle", {31'b0, txd}, 32'h1);
        check("tx_idle_after_reset", {31'b0, tx_idle}, 32'h1);

        // 2: single byte 0xA5 at 4 cycles per bit
        bus_write(BASE + 32'h8, 32'd4);
        expect_frame(8'hA5, 4);
        bus_write(BASE, 32'hFFFF_FFA5);
        check("txd_after_push_edge", {31'b0, txd}, 32'h1);
        check("tx_idle_after_push", {31'b0, tx_idle}, 32'h0);
        @(posedge clk);
        #1;
        check("txd_start_after_pop_edge", {31'b0, txd}, 32'h0);
        bus_read(BASE + 32'h4, r);
        check("status_busy_empty", r, 32'h0000_0005);
        wait_drain("drain_a5", 200);
        check("tx_idle_after_a5", {31'b0, tx_idle}, 32'h1);

        // 3: overflow with six back-to-back stores
        for (int i = 1; i <= 5; i++) expect_frame(8'(i), 4);
        for (int i = 1; i <= 6; i++) bus_write(BASE, i);
        bus_read(BASE + 32'h4, r);
        check("status_full_ovf", r, 32'h0000_004B);
        bus_write(BASE + 32'h4, 32'h0000_0007);
        bus_read(BASE + 32'h4, r);
        check("ovf_kept_without_bit3", r, 32'h0000_004B);
        bus_write(BASE + 32'h4, 32'h0000_0008);
        bus_read(BASE + 32'h4, r);
        check("ovf_cleared", r, 32'h0000_0043);
        wait_drain("drain_overflow", 800);
        bus_read(BASE + 32'h4, r);
        check("status_after_overflow_drain", r, 32'h0000_0004);

        // 4: DIVISOR=0 acts as 1; mid-frame DIVISOR write applies to next frame
        bus_write(BASE + 32'h8, 32'd0);
        expect_frame(8'h3C, 1);
        expect_frame(8'hC3, 8);
        bus_write(BASE, 32'h3C);
        bus_write(BASE, 32'hC3);
        bus_write(BASE + 32'h8, 32'd8);
        wait_drain("drain_div_change", 300);
        bus_read(BASE + 32'h8, r);
        check("divisor_readback_8", r, 32'd8);

        // 5: reset in the middle of the data bits
        bus_write(BASE + 32'h8, 32'd4);
        expect_frame(8'h5A, 4);
        bus_write(BASE, 32'h5A);
        bus_write(BASE, 32'h11);
        repeat (16) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("txd_high_on_reset", {31'b0, txd}, 32'h1);
        check("tx_idle_on_reset", {31'b0, tx_idle}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus_read(BASE + 32'h4, r);
        check("status_after_midframe_reset", r, 32'h0000_0004);
        bus_read(BASE + 32'h8, r);
        check("divisor_after_midframe_reset", r, 32'd868);
        bus_write(BASE + 32'h8, 32'd4);
        expect_frame(8'h96, 4);
        bus_write(BASE, 32'h96);
        wait_drain("drain_after_reset", 200);

        // 6: accesses outside the window and to the reserved word
        bus_write(BASE + 32'h10, 32'h55);
        check("hit_outside_window", {31'b0, hit}, 32'h0);
        check("rdata_outside_window", rdata, 32'h0);
        bus_write(BASE + 32'h18, 32'h1234);
        bus_write(BASE - 32'h8, 32'h1234);
        bus_read(BASE + 32'h18, r);
        check("rdata_alias_divisor_outside", r, 32'h0);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus_read(BASE + 32'hC, r);
        check("reserved_reads_zero", r, 32'h0);
        check("hit_reserved", {31'b0, hit}, 32'h1);
        bus_read(BASE, r);
        check("txdata_reads_zero", r, 32'h0);
        repeat (20) @(posedge clk);
        bus_read(BASE + 32'h4, r);
        check("status_unchanged_outside", r, 32'h0000_0004);
        bus_read(BASE + 32'h8, r);
        check("divisor_unchanged_outside", r, 32'd4);
        check("txd_quiet_outside", {31'b0, txd}, 32'h1);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
